// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//   Measures the spacing, in clk_in cycles, between consecutive rising edges
//   of an asynchronous pulse train. This is the inverse of clk_divider: when
//   it is fed clk_divider's clk_out at max_in=N, it reports N. Periods too
//   long for SIZE bits are flagged rather than wrapped.
//
// Parameters
//   SIZE        width of the period counter and period_out (max period 2**SIZE-1)
//   MIN_PERIOD  rising edges seen with count < MIN_PERIOD are ignored (glitch filter)
//
// Ports
//   clk_in        system clock, all logic on posedge
//   reset_in      asynchronous, active-high reset
//   enable_in     1 = measure; 0 = abort and hold in IDLE
//   sig_in        asynchronous pulse train
//   period_out    last measured period; holds between updates
//   valid_out     one-cycle strobe, period_out updated this cycle
//   overflow_out  period exceeded 2**SIZE-1; held until the next accepted edge
module pulse_period_meter #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned MIN_PERIOD = 1
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            enable_in,
  input  logic            sig_in,
  output logic [SIZE-1:0] period_out,
  output logic            valid_out,
  output logic            overflow_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    OVFL    = 2'd2
  } state_t;

  localparam logic [SIZE-1:0] CNT_MAX = '1;
  localparam logic [SIZE-1:0] CNT_ONE = SIZE'(1);
  localparam logic [SIZE-1:0] MIN_CNT = SIZE'(MIN_PERIOD);

  state_t          state;
  logic [SIZE-1:0] cnt;
  logic            s1, s2, s3;
  logic            rise;

  // Synchroniser flops reset to 1 so a sig_in already high at reset release
  // is not mistaken for a rising edge.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state        <= IDLE;
      cnt          <= '0;
      period_out   <= '0;
      valid_out    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (!enable_in) begin
        // Abort dominates any edge; the last result and overflow flag hold.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE, OVFL: begin
            // First edge (or first edge after overflow) only starts a count;
            // there is no valid period to report yet.
            if (rise) begin
              state        <= MEASURE;
              cnt          <= CNT_ONE;
              overflow_out <= 1'b0;
            end
          end
          MEASURE: begin
            if (rise && (cnt >= MIN_CNT)) begin
              // Accepting an edge takes priority over saturation, so a period
              // of exactly 2**SIZE-1 is still reported.
              period_out <= cnt;
              valid_out  <= 1'b1;
              cnt        <= CNT_ONE;
            end else if (cnt == CNT_MAX) begin
              // Saturate instead of wrapping; the count is no longer meaningful.
              state        <= OVFL;
              overflow_out <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
